// File: rtl/aes_pkg.sv
// Shared AES decrypt-side definitions: inverse S-box table, engine state encoding, state width.
// Pure constants and types; no logic, no latency.
package aes_pkg;

  localparam int AES_STATE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sbox.sv
// Single-byte AES inverse S-box lookup.
// Combinational, zero latency; no handshake.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = INV_SBOX[din];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: LANES bytes per cycle, result ready N+1 cycles after acceptance (N = 16/LANES).
// Result held in DONE until out_ready; in_ready only in IDLE, so no new state is taken while one is pending.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] data_out,
  output logic                   busy
);

  localparam int N       = 16 / LANES;
  localparam int CHUNK_W = 8 * LANES;
  localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [N-1:0][CHUNK_W-1:0]    data_q, data_d;
  logic [CNT_W-1:0]             chunk_idx;
  logic [CHUNK_W-1:0]           chunk_in;
  logic [CHUNK_W-1:0]           chunk_out;

  // Chunk 0 is the most significant slice, i.e. packed index N-1.
  assign chunk_idx = LAST - count_q;
  assign chunk_in  = data_q[chunk_idx];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sbox u_inv_sbox (
      .din  (chunk_in[CHUNK_W-1-8*l -: 8]),
      .dout (chunk_out[CHUNK_W-1-8*l -: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = data_in;
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        data_d[chunk_idx] = chunk_out;
        if (count_q == LAST) begin
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign data_out  = data_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter at LANES=4: known vectors, SubBytes round trip, back-pressure,
// mid-operation reset and back-to-back streaming; forward S-box is computed from GF(2^8) arithmetic.
module tb_inv_sub_bytes_iter;

  localparam int LANES   = 4;
  localparam int N       = 16 / LANES;
  localparam int EXP_LAT = N + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_fwd [256];
  logic [127:0] bx [4];

  inv_sub_bytes_iter #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] fwd_state(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_fwd[x[127-8*i -: 8]];
    return r;
  endfunction

  // Presents din, waits for out_valid; reports latency (from acceptance cycle) and busy cycles.
  task automatic start_op(input logic [127:0] din, output int lat, output int busy_cnt);
    int edges;
    in_valid = 1'b1;
    data_in  = din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = '0;
    edges = 0;
    busy_cnt = 0;
    while (!out_valid && edges < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      edges++;
    end
    lat = edges + 1;
  endtask

  task automatic run_one(input string tag, input logic [127:0] din, input logic [127:0] exp);
    int lat, bc;
    check({tag, " in_ready"}, 128'(in_ready), 128'(1));
    start_op(din, lat, bc);
    check({tag, " latency"}, 128'(lat), 128'(EXP_LAT));
    check({tag, " busy_cycles"}, 128'(bc), 128'(N));
    check({tag, " data_out"}, data_out, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid_drop"}, 128'(out_valid), 128'(0));
    check({tag, " in_ready_back"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    int lat, bc, cyc, in_idx, out_idx, last_x;
    logic acc, xfer;
    logic [127:0] x;

    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_fwd[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
    #12;
    check("rst in_ready", 128'(in_ready), 128'(1));
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst busy", 128'(busy), 128'(0));
    check("rst data_out", data_out, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_one("all63", {16{8'h63}}, 128'h0);
    run_one("known", {8'h63, 8'h7c, 8'h16, 8'hed, 8'h00, {11{8'h52}}},
                     {8'h00, 8'h01, 8'hff, 8'h53, 8'h52, {11{8'h48}}});

    // Back-pressure: hold DONE for 20 cycles while a different in_valid is offered.
    start_op({16{8'h52}}, lat, bc);
    check("bp latency", 128'(lat), 128'(EXP_LAT));
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      data_in  = {16{8'h63}};
      @(posedge clk); #1;
      check("bp out_valid", 128'(out_valid), 128'(1));
      check("bp data_out", data_out, {16{8'h48}});
      check("bp in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff in_ready", 128'(in_ready), 128'(1));
    check("handoff busy", 128'(busy), 128'(0));
    check("handoff out_valid", 128'(out_valid), 128'(0));
    in_valid = 1'b0;
    data_in  = '0;
    @(posedge clk); #1;

    // Reset with count=2 in BUSY.
    in_valid = 1'b1;
    data_in  = {16{8'h7c}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", 128'(in_ready), 128'(1));
    check("midrst out_valid", 128'(out_valid), 128'(0));
    check("midrst busy", 128'(busy), 128'(0));
    check("midrst data_out", data_out, 128'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_one("post_rst", {8'hed, {15{8'h16}}}, {8'h53, {15{8'hff}}});

    for (int t = 0; t < 100; t++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      run_one("roundtrip", fwd_state(x), x);
    end

    // Back-to-back streaming with in_valid and out_ready held high.
    for (int i = 0; i < 4; i++) bx[i] = {$urandom, $urandom, $urandom, $urandom};
    in_idx = 0; out_idx = 0; cyc = 0; last_x = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = fwd_state(bx[0]);
    while (out_idx < 4 && cyc < 80) begin
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        check("b2b data", data_out, bx[out_idx]);
        if (out_idx > 0) check("b2b interval", 128'(cyc - last_x), 128'(N + 2));
        last_x = cyc;
        out_idx++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        in_idx++;
        if (in_idx < 4) data_in = fwd_state(bx[in_idx]);
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b outputs", 128'(out_idx), 128'(4));
    check("b2b inputs", 128'(in_idx), 128'(4));
    @(posedge clk); #1;
    check("b2b idle out_valid", 128'(out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
